// File: rtl/multdiv_ctrl.sv
// Sequences one MULT/DIV through the shared multi-cycle unit and writes the result back.
// Accept at cycle 0, start strobe at cycle 1, writeback one cycle after md_ready (or after the timeout).
// Stalls the pipeline from the accept cycle through WAIT; issue outside IDLE is ignored.
module multdiv_ctrl #(
  parameter int WIDTH         = 32,
  parameter int TIMEOUT       = 40,
  parameter int EXC_REG       = 30,
  parameter int MULT_EXC_CODE = 4,
  parameter int DIV_EXC_CODE  = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic             is_mult,
  input  logic             is_div,
  input  logic [4:0]       rd_in,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_exception,
  input  logic             md_ready,
  output logic             ctrl_mult,
  output logic             ctrl_div,
  output logic [WIDTH-1:0] md_operand_a,
  output logic [WIDTH-1:0] md_operand_b,
  output logic             stall,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] MULT_CODE_W = WIDTH'(MULT_EXC_CODE);
  localparam logic [WIDTH-1:0] DIV_CODE_W  = WIDTH'(DIV_EXC_CODE);
  localparam logic [4:0]       EXC_RD      = 5'(EXC_REG);
  // WAIT lasts at most TIMEOUT cycles: the counter reads 0 in the first WAIT cycle.
  localparam logic [7:0]       CNT_LAST    = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             op_mult_q, op_mult_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [4:0]       rd_q, rd_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             terr_q, terr_d;

  logic             accept;
  logic             timeout_hit;
  logic             wb_en;

  // Only a well-formed MULT xor DIV in IDLE is taken; both set together is dropped.
  assign accept      = (state_q == ST_IDLE) && issue_valid && (is_mult ^ is_div);
  assign timeout_hit = (cnt_q == CNT_LAST);

  // Next-state and latch update logic.
  always_comb begin
    state_d   = state_q;
    op_mult_d = op_mult_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rd_d      = rd_q;
    res_d     = res_q;
    exc_d     = exc_q;
    cnt_d     = cnt_q;
    terr_d    = terr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_mult_d = is_mult;
          opa_d     = operand_a;
          opb_d     = operand_b;
          rd_d      = rd_in;
          res_d     = '0;
          exc_d     = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        // md_ready is not looked at here; a stale ready cannot complete the new op.
        cnt_d   = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (md_ready) begin
          // A ready in the final WAIT cycle beats the timeout.
          res_d   = md_result;
          exc_d   = md_exception;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          terr_d  = 1'b1;
          exc_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latch registers, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_mult_q <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      rd_q      <= 5'd0;
      res_q     <= '0;
      exc_q     <= 1'b0;
      cnt_q     <= 8'd0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_mult_q <= op_mult_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      rd_q      <= rd_d;
      res_q     <= res_d;
      exc_q     <= exc_d;
      cnt_q     <= cnt_d;
      terr_q    <= terr_d;
    end
  end

  // Normal writes to $r0 are dropped; exception writes always go out.
  assign wb_en = (state_q == ST_DONE) && (exc_q || (rd_q != 5'd0));

  // Pipeline-facing outputs; forced quiet while reset is held.
  always_comb begin
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    stall     = 1'b0;
    wb_valid  = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = '0;
    if (!reset) begin
      ctrl_mult = (state_q == ST_START) && op_mult_q;
      ctrl_div  = (state_q == ST_START) && !op_mult_q;
      stall     = accept || (state_q == ST_START) || (state_q == ST_WAIT);
      if (wb_en) begin
        wb_valid = 1'b1;
        if (exc_q) begin
          wb_rd   = EXC_RD;
          wb_data = op_mult_q ? MULT_CODE_W : DIV_CODE_W;
        end else begin
          wb_rd   = rd_q;
          wb_data = res_q;
        end
      end
    end
  end

  assign md_operand_a = opa_q;
  assign md_operand_b = opb_q;
  assign timeout_err  = terr_q;

endmodule
